// File: rtl/fix_pkg.sv
// Shared constants, frame template, state enums and byte helpers for the FIX engine.
package fix_pkg;

    localparam logic [7:0] SOH         = 8'h01;
    localparam logic [7:0] CONNECT_CMD = 8'h80;

    // Common frame header "8=FIX.4.2^9=5^35="
    localparam int HDR_LEN = 17;
    localparam logic [7:0] HDR [0:16] = '{
        8'h38, 8'h3D, 8'h46, 8'h49, 8'h58, 8'h2E, 8'h34, 8'h2E, 8'h32, 8'h01,
        8'h39, 8'h3D, 8'h35, 8'h01, 8'h33, 8'h35, 8'h3D
    };

    localparam logic [7:0] MT_LOGON     = 8'h41;  // 'A'
    localparam logic [7:0] MT_HEARTBEAT = 8'h30;  // '0'
    localparam logic [7:0] MT_TESTREQ   = 8'h31;  // '1'
    localparam logic [7:0] MT_LOGOUT    = 8'h35;  // '5'

    // Byte positions inside a 26-byte frame
    localparam logic [4:0] IDX_SUM_LAST = 5'd18;  // last byte covered by the checksum
    localparam logic [4:0] IDX_LAST     = 5'd25;  // trailing SOH

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CONN_REQ  = 3'd1,
        S_WAIT_CONN = 3'd2,
        S_LOGON_TX  = 3'd3,
        S_ACTIVE    = 3'd4
    } sess_state_e;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_CMD   = 2'd1,
        TX_FRAME = 2'd2
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_TAG  = 2'd0,
        RX_VAL  = 2'd1,
        RX_SKIP = 2'd2
    } rx_state_e;

    // ASCII decimal digit of an 8-bit value: pos 0 = hundreds, 1 = tens, 2 = units
    function automatic logic [7:0] dec_digit(input logic [7:0] v, input logic [1:0] pos);
        logic [7:0] d;
        case (pos)
            2'd0:    d = v / 8'd100;
            2'd1:    d = (v / 8'd10) % 8'd10;
            default: d = v % 8'd10;
        endcase
        return 8'h30 + d;
    endfunction

    // Byte at position idx of a frame with the given MsgType and checksum
    function automatic logic [7:0] frame_byte(input logic [4:0] idx, input logic [7:0] mt,
                                              input logic [7:0] sum);
        logic [7:0] b;
        if (idx < 5'd17) begin
            b = HDR[idx];
        end else begin
            case (idx)
                5'd17:   b = mt;
                5'd18:   b = SOH;
                5'd19:   b = 8'h31;  // '1'
                5'd20:   b = 8'h30;  // '0'
                5'd21:   b = 8'h3D;  // '='
                5'd22:   b = dec_digit(sum, 2'd0);
                5'd23:   b = dec_digit(sum, 2'd1);
                5'd24:   b = dec_digit(sum, 2'd2);
                5'd25:   b = SOH;
                default: b = 8'h00;
            endcase
        end
        return b;
    endfunction

endpackage

// File: rtl/fix_tx_framer.sv
// Outbound framer: emits either a one-byte connect command or a full FIX frame
// with checksum trailer. message_o always shows the byte currently offered; it
// is written (and the pointer advances) only in cycles where the FIFO is not full.
module fix_tx_framer
    import fix_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic [7:0] type_i,
    input  logic       cmd_i,
    input  logic [1:0] host_i,
    input  logic       fifo_full_i,
    output logic       fifo_write_o,
    output logic [7:0] message_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] type_o
);

    tx_state_e  state_q, state_d;
    logic [4:0] idx_q, idx_d;
    logic [7:0] sum_q, sum_d;
    logic [7:0] byte_q, byte_d;
    logic [7:0] type_q, type_d;
    logic       accept_s;
    logic       done_s;

    assign accept_s     = (state_q != TX_IDLE) && !fifo_full_i;
    assign fifo_write_o = accept_s;
    assign message_o    = byte_q;
    assign busy_o       = (state_q != TX_IDLE);
    assign done_o       = done_s;
    assign type_o       = type_q;

    // Next-state: load on start, advance pointer and checksum on each accepted byte
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        byte_d  = byte_q;
        type_d  = type_q;
        done_s  = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (start_i) begin
                    idx_d = 5'd0;
                    sum_d = 8'd0;
                    if (cmd_i) begin
                        state_d = TX_CMD;
                        byte_d  = CONNECT_CMD | {6'd0, host_i};
                        type_d  = 8'h00;
                    end else begin
                        state_d = TX_FRAME;
                        byte_d  = HDR[0];
                        type_d  = type_i;
                    end
                end else begin
                    byte_d = 8'h00;
                end
            end
            TX_CMD: begin
                if (accept_s) begin
                    done_s  = 1'b1;
                    state_d = TX_IDLE;
                    byte_d  = 8'h00;
                end else begin
                    done_s = 1'b0;
                end
            end
            TX_FRAME: begin
                if (accept_s) begin
                    if (idx_q <= IDX_SUM_LAST) begin
                        sum_d = sum_q + byte_q;
                    end else begin
                        sum_d = sum_q;
                    end
                    if (idx_q == IDX_LAST) begin
                        done_s  = 1'b1;
                        state_d = TX_IDLE;
                        byte_d  = 8'h00;
                    end else begin
                        idx_d  = idx_q + 5'd1;
                        byte_d = frame_byte(idx_d, type_q, sum_d);
                    end
                end else begin
                    done_s = 1'b0;
                end
            end
            default: begin
                state_d = TX_IDLE;
                byte_d  = 8'h00;
            end
        endcase
    end

    // Framer registers with synchronous reset; reset abandons any frame in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= TX_IDLE;
            idx_q   <= 5'd0;
            sum_q   <= 8'd0;
            byte_q  <= 8'h00;
            type_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            byte_q  <= byte_d;
            type_q  <= type_d;
        end
    end

endmodule

// File: rtl/fix_engine.sv
// FIX session engine: session FSM, inbound tag/value parser and response
// scheduling; outbound bytes are produced by fix_tx_framer.
module fix_engine
    import fix_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       connect_i,
    input  logic [1:0] connect_to_host_i,
    input  logic       connected_i,
    input  logic [1:0] connected_host_addr_i,
    input  logic [7:0] message_i,
    input  logic       valid_i,
    input  logic       fifo_full_i,
    input  logic       new_message_i,
    output logic       fifo_write_o,
    output logic [7:0] message_o
);

    sess_state_e state_q, state_d;
    logic [1:0]  host_q, host_d;
    logic        start_q, start_d;
    logic        start_cmd_q, start_cmd_d;
    logic [7:0]  start_type_q, start_type_d;
    logic        pend_q, pend_d;
    logic [7:0]  pend_type_q, pend_type_d;

    rx_state_e   rx_state_q, rx_state_d;
    logic [7:0]  tag_q, tag_d;
    logic        first_q, first_d;
    logic [7:0]  msgtype_q, msgtype_d;
    logic        resp_valid_s;
    logic [7:0]  resp_type_s;
    logic        is_digit_s;

    logic        tx_busy_s;
    logic        tx_done_s;
    logic [7:0]  tx_type_s;

    assign is_digit_s = (message_i >= 8'h30) && (message_i <= 8'h39);

    // Inbound parser: decimal tag accumulation, MsgType capture, end on tag 10
    always_comb begin
        rx_state_d   = rx_state_q;
        tag_d        = tag_q;
        first_d      = first_q;
        msgtype_d    = msgtype_q;
        resp_valid_s = 1'b0;
        resp_type_s  = 8'h00;
        if ((state_q != S_ACTIVE) || new_message_i) begin
            rx_state_d = RX_TAG;
            tag_d      = 8'd0;
            first_d    = 1'b0;
            msgtype_d  = 8'h00;
        end else begin
            rx_state_d = rx_state_q;
        end
        if ((state_q == S_ACTIVE) && valid_i) begin
            case (rx_state_d)
                RX_TAG: begin
                    if (is_digit_s) begin
                        // saturate long tags so they never alias onto 10 or 35
                        if (tag_d > 8'd24) begin
                            tag_d = 8'd255;
                        end else begin
                            tag_d = (tag_d * 8'd10) + {4'd0, message_i[3:0]};
                        end
                    end else if (message_i == 8'h3D) begin
                        rx_state_d = RX_VAL;
                        first_d    = 1'b1;
                    end else if (message_i == SOH) begin
                        tag_d = 8'd0;
                    end else begin
                        rx_state_d = RX_SKIP;
                    end
                end
                RX_VAL: begin
                    if (message_i == SOH) begin
                        if (tag_d == 8'd10) begin
                            if (msgtype_d == MT_TESTREQ) begin
                                resp_valid_s = 1'b1;
                                resp_type_s  = MT_HEARTBEAT;
                            end else if (msgtype_d == MT_LOGOUT) begin
                                resp_valid_s = 1'b1;
                                resp_type_s  = MT_LOGOUT;
                            end else begin
                                resp_valid_s = 1'b0;
                            end
                            msgtype_d = 8'h00;
                        end else begin
                            msgtype_d = msgtype_d;
                        end
                        rx_state_d = RX_TAG;
                        tag_d      = 8'd0;
                        first_d    = 1'b0;
                    end else begin
                        if (first_d && (tag_d == 8'd35)) begin
                            msgtype_d = message_i;
                        end else begin
                            msgtype_d = msgtype_d;
                        end
                        first_d = 1'b0;
                    end
                end
                RX_SKIP: begin
                    if (message_i == SOH) begin
                        rx_state_d = RX_TAG;
                        tag_d      = 8'd0;
                    end else begin
                        rx_state_d = RX_SKIP;
                    end
                end
                default: begin
                    rx_state_d = RX_TAG;
                    tag_d      = 8'd0;
                end
            endcase
        end else begin
            resp_valid_s = 1'b0;
        end
    end

    // Session FSM next-state, frame launch and single-entry response queue
    always_comb begin
        state_d      = state_q;
        host_d       = host_q;
        start_d      = 1'b0;
        start_cmd_d  = start_cmd_q;
        start_type_d = start_type_q;
        pend_d       = pend_q;
        pend_type_d  = pend_type_q;
        case (state_q)
            S_IDLE: begin
                pend_d = 1'b0;
                if (connect_i) begin
                    host_d      = connect_to_host_i;
                    start_d     = 1'b1;
                    start_cmd_d = 1'b1;
                    state_d     = S_CONN_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CONN_REQ: begin
                if (tx_done_s) begin
                    state_d = S_WAIT_CONN;
                end else begin
                    state_d = S_CONN_REQ;
                end
            end
            S_WAIT_CONN: begin
                if (connected_i && (connected_host_addr_i == host_q)) begin
                    start_d      = 1'b1;
                    start_cmd_d  = 1'b0;
                    start_type_d = MT_LOGON;
                    state_d      = S_LOGON_TX;
                end else begin
                    state_d = S_WAIT_CONN;
                end
            end
            S_LOGON_TX: begin
                if (tx_done_s) begin
                    state_d = S_ACTIVE;
                end else begin
                    state_d = S_LOGON_TX;
                end
            end
            S_ACTIVE: begin
                if (resp_valid_s) begin
                    pend_d      = 1'b1;
                    pend_type_d = resp_type_s;
                end else begin
                    pend_d = pend_q;
                end
                if (tx_done_s && (tx_type_s == MT_LOGOUT)) begin
                    state_d = S_IDLE;
                    pend_d  = 1'b0;
                end else if (pend_d && !tx_busy_s && !start_q) begin
                    start_d      = 1'b1;
                    start_cmd_d  = 1'b0;
                    start_type_d = pend_type_d;
                    pend_d       = 1'b0;
                end else begin
                    state_d = S_ACTIVE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Session, launch and parser registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            host_q       <= 2'd0;
            start_q      <= 1'b0;
            start_cmd_q  <= 1'b0;
            start_type_q <= 8'h00;
            pend_q       <= 1'b0;
            pend_type_q  <= 8'h00;
            rx_state_q   <= RX_TAG;
            tag_q        <= 8'd0;
            first_q      <= 1'b0;
            msgtype_q    <= 8'h00;
        end else begin
            state_q      <= state_d;
            host_q       <= host_d;
            start_q      <= start_d;
            start_cmd_q  <= start_cmd_d;
            start_type_q <= start_type_d;
            pend_q       <= pend_d;
            pend_type_q  <= pend_type_d;
            rx_state_q   <= rx_state_d;
            tag_q        <= tag_d;
            first_q      <= first_d;
            msgtype_q    <= msgtype_d;
        end
    end

    fix_tx_framer u_framer (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_q),
        .type_i       (start_type_q),
        .cmd_i        (start_cmd_q),
        .host_i       (host_q),
        .fifo_full_i  (fifo_full_i),
        .fifo_write_o (fifo_write_o),
        .message_o    (message_o),
        .busy_o       (tx_busy_s),
        .done_o       (tx_done_s),
        .type_o       (tx_type_s)
    );

endmodule

// File: tb/tb_fix_engine.sv
// Self-checking bench for fix_engine: vector table of inbound MsgTypes,
// randomized inbound traffic and FIFO stalls against a string-level frame model,
// plus hand-written connect / stall / reset sequences.
module tb_fix_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic       connect_i;
    logic [1:0] connect_to_host_i;
    logic       connected_i;
    logic [1:0] connected_host_addr_i;
    logic [7:0] message_i;
    logic       valid_i;
    logic       fifo_full_i;
    logic       new_message_i;
    logic       fifo_write_o;
    logic [7:0] message_o;

    int checks = 0;
    int errors = 0;
    int full_viol = 0;
    logic [7:0] cap_q[$];
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] in_type;
        logic       has_resp;
        logic [7:0] resp_type;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    fix_engine dut (
        .clk                   (clk),
        .rst                   (rst),
        .connect_i             (connect_i),
        .connect_to_host_i     (connect_to_host_i),
        .connected_i           (connected_i),
        .connected_host_addr_i (connected_host_addr_i),
        .message_i             (message_i),
        .valid_i               (valid_i),
        .fifo_full_i           (fifo_full_i),
        .new_message_i         (new_message_i),
        .fifo_write_o          (fifo_write_o),
        .message_o             (message_o)
    );

    // Record every FIFO write mid-cycle
    always @(negedge clk) begin
        if (fifo_write_o === 1'b1) begin
            cap_q.push_back(message_o);
            if (fifo_full_i) full_viol++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input bit stall);
        for (int i = 0; i < n; i++) begin
            fifo_full_i = stall ? ($urandom_range(0, 9) < 3) : 1'b0;
            tick();
        end
        fifo_full_i = 1'b0;
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    // Reference frame: header, MsgType, SOH, then "10=" + 3-digit mod-256 sum + SOH
    task automatic model_frame(input logic [7:0] t);
        int start;
        int sum;
        start = exp_q.size();
        sum = 0;
        push_str("8=FIX.4.2"); exp_q.push_back(8'h01);
        push_str("9=5");       exp_q.push_back(8'h01);
        push_str("35=");       exp_q.push_back(t);
        exp_q.push_back(8'h01);
        for (int i = start; i < exp_q.size(); i++) sum += int'(exp_q[i]);
        sum = sum % 256;
        push_str($sformatf("10=%03d", sum));
        exp_q.push_back(8'h01);
    endtask

    task automatic compare_out(input string name);
        int n;
        check({name, "_len"}, cap_q.size(), exp_q.size());
        n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check($sformatf("%s[%0d]", name, i), cap_q[i], exp_q[i]);
        cap_q.delete();
        exp_q.delete();
    endtask

    // Send an inbound string ('^' stands for SOH), optionally with idle gaps
    task automatic send_str(input string s, input bit gaps);
        logic [7:0] b;
        for (int i = 0; i < s.len(); i++) begin
            b = (s[i] == "^") ? 8'h01 : s[i];
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    valid_i   = 1'b0;
                    message_i = 8'($urandom);
                    tick();
                end
            end
            valid_i   = 1'b1;
            message_i = b;
            tick();
        end
        valid_i = 1'b0;
    endtask

    initial begin
        int n;
        logic [7:0] t;
        logic [7:0] pool[4];

        vecs[0] = '{8'h31, 1'b1, 8'h30};
        vecs[1] = '{8'h30, 1'b0, 8'h00};
        vecs[2] = '{8'h41, 1'b0, 8'h00};
        vecs[3] = '{8'h44, 1'b0, 8'h00};
        vecs[4] = '{8'h31, 1'b1, 8'h30};
        vecs[5] = '{8'h32, 1'b0, 8'h00};
        pool = '{8'h31, 8'h30, 8'h32, 8'h31};

        rst = 1'b1; connect_i = 1'b0; connect_to_host_i = 2'd0; connected_i = 1'b0;
        connected_host_addr_i = 2'd0; message_i = 8'h00; valid_i = 1'b0;
        fifo_full_i = 1'b0; new_message_i = 1'b0;
        repeat (3) tick();
        check("reset_write", fifo_write_o, 1'b0);
        check("reset_msg", message_o, 8'h00);
        rst = 1'b0;
        tick();
        cap_q.delete();

        // connect request: command byte one cycle after connect_i is sampled
        connect_to_host_i = 2'd1; connect_i = 1'b1;
        tick();
        connect_i = 1'b0;
        check("cmd_lat0", fifo_write_o, 1'b0);
        tick();
        check("cmd_lat1", {fifo_write_o, message_o}, {1'b1, 8'h81});
        run(5, 1'b0);
        exp_q.push_back(8'h81);
        compare_out("connect");

        // wrong host answers and a connect_i outside IDLE are both ignored
        connected_host_addr_i = 2'd2; connected_i = 1'b1;
        connect_i = 1'b1; connect_to_host_i = 2'd2;
        tick();
        connected_i = 1'b0; connect_i = 1'b0;
        run(30, 1'b0);
        check("wrong_host_writes", cap_q.size(), 0);

        // Logon with a 5-cycle FIFO stall in the middle
        connected_host_addr_i = 2'd1; connected_i = 1'b1;
        tick();
        connected_i = 1'b0;
        check("logon_lat0", fifo_write_o, 1'b0);
        tick();
        check("logon_first", {fifo_write_o, message_o}, {1'b1, 8'h38});
        run(5, 1'b0);
        fifo_full_i = 1'b1;
        n = cap_q.size();
        repeat (5) tick();
        check("stall_no_write", cap_q.size(), n);
        fifo_full_i = 1'b0;
        run(40, 1'b0);
        check("logon_ck_h", cap_q[22], 8'h31);
        check("logon_ck_t", cap_q[23], 8'h37);
        check("logon_ck_u", cap_q[24], 8'h38);
        model_frame(8'h41);
        compare_out("logon");

        // table of inbound MsgTypes in ACTIVE
        for (int i = 0; i < 6; i++) begin
            send_str($sformatf("8=FIX.4.2^9=5^35=%c^112=abc^10=123^", vecs[i].in_type), 1'b0);
            run(60, 1'b0);
            if (vecs[i].has_resp) model_frame(vecs[i].resp_type);
            compare_out($sformatf("vec%0d", i));
        end

        // non-digit tag invalidates the field, so no MsgType is captured
        send_str("8=FIX.4.2^9=5^3X=1^10=000^", 1'b0);
        run(40, 1'b0);
        compare_out("bad_tag");

        // randomized traffic with input gaps and FIFO stalls
        for (int i = 0; i < 12; i++) begin
            t = pool[$urandom_range(0, 3)];
            send_str($sformatf("8=FIX.4.2^9=5^35=%c^58=x%0d^10=000^", t, i), 1'b1);
            run(100, 1'b1);
            if (t == 8'h31) model_frame(8'h30);
            compare_out($sformatf("rand%0d", i));
        end

        // new_message_i clears a half-parsed TestRequest
        send_str("8=FIX.4.2^9=5^35=1^", 1'b1);
        new_message_i = 1'b1;
        tick();
        new_message_i = 1'b0;
        send_str("8=FIX.4.2^9=5^10=000^", 1'b1);
        send_str("8=FIX.4.2^9=5^35=0^10=000^", 1'b1);
        run(40, 1'b0);
        compare_out("newmsg");

        // Logout answered with Logout, then back to IDLE
        send_str("8=FIX.4.2^9=5^35=5^10=000^", 1'b0);
        run(100, 1'b1);
        model_frame(8'h35);
        compare_out("logout");

        // inbound bytes in IDLE are discarded
        send_str("8=FIX.4.2^9=5^35=1^10=000^", 1'b0);
        run(40, 1'b0);
        compare_out("idle_discard");

        // a new connect is accepted after Logout
        connect_to_host_i = 2'd3; connect_i = 1'b1;
        tick();
        connect_i = 1'b0;
        run(6, 1'b0);
        exp_q.push_back(8'h83);
        compare_out("reconnect");

        // reset in the middle of a Logon frame abandons it
        connected_host_addr_i = 2'd3; connected_i = 1'b1;
        tick();
        connected_i = 1'b0;
        repeat (6) tick();
        check("pre_reset_writes", (cap_q.size() > 0) ? 1 : 0, 1);
        rst = 1'b1;
        tick();
        cap_q.delete();
        repeat (3) tick();
        rst = 1'b0;
        run(40, 1'b0);
        check("post_reset_writes", cap_q.size(), 0);
        check("post_reset_msg", message_o, 8'h00);

        check("write_while_full", full_viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
